// File: rtl/accum_thread.sv
// rtl/accum_thread.sv - multi-lane multiply-accumulate dot-product engine.
// Consumes ceil(k_len/ADDER_WIDTH) a/b beats and presents one result with a valid/ready handshake.
module accum_thread #(
  parameter int DATA_WIDTH        = 8,
  parameter int ADDER_WIDTH       = 4,
  parameter int K_MAX             = 16,
  parameter bit SIGNED            = 1'b0,
  parameter int OUTPUT_DATA_WIDTH = 2*DATA_WIDTH + $clog2(K_MAX)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [$clog2(K_MAX+1)-1:0]        k_len,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [ADDER_WIDTH*DATA_WIDTH-1:0] a,
  input  logic [ADDER_WIDTH*DATA_WIDTH-1:0] b,
  output logic [OUTPUT_DATA_WIDTH-1:0]      res,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic                              busy
);

  localparam int KW = $clog2(K_MAX+1);
  localparam int PW = 2*DATA_WIDTH;
  localparam int OW = OUTPUT_DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] rem_q, rem_d;
  logic [OW-1:0] acc_q, acc_d;
  logic [OW-1:0] res_q, res_d;
  logic [OW-1:0] beat_sum;
  logic          final_beat;

  // rem_q is the number of elements still owed; lanes at or beyond it are masked off
  always_comb begin : lane_sum
    logic [DATA_WIDTH-1:0] a_lane;
    logic [DATA_WIDTH-1:0] b_lane;
    logic [PW-1:0]         prod;
    beat_sum = '0;
    a_lane   = '0;
    b_lane   = '0;
    prod     = '0;
    for (int i = 0; i < ADDER_WIDTH; i++) begin
      a_lane = a[i*DATA_WIDTH +: DATA_WIDTH];
      b_lane = b[i*DATA_WIDTH +: DATA_WIDTH];
      if (SIGNED) begin
        prod = PW'($signed(a_lane)) * PW'($signed(b_lane));
      end else begin
        prod = PW'(a_lane) * PW'(b_lane);
      end
      if (i < int'(rem_q)) begin
        if (SIGNED) begin
          beat_sum = beat_sum + OW'($signed(prod));
        end else begin
          beat_sum = beat_sum + OW'(prod);
        end
      end
    end
  end

  assign final_beat = (int'(rem_q) <= ADDER_WIDTH);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = '0;
          if (k_len == '0) begin
            rem_d   = '0;
            res_d   = '0;
            state_d = DONE;
          end else begin
            rem_d   = (int'(k_len) > K_MAX) ? KW'(K_MAX) : k_len;
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d = acc_q + beat_sum;
          if (final_beat) begin
            rem_d   = '0;
            res_d   = acc_q + beat_sum;
            state_d = DONE;
          end else begin
            rem_d = rem_q - KW'(ADDER_WIDTH);
          end
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign res_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign res       = res_q;

endmodule

// File: tb/tb_accum_thread.sv
// tb/tb_accum_thread.sv - directed vector bench for accum_thread (unsigned and signed instances).
module tb_accum_thread;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  k_len;
  logic        in_valid;
  logic [31:0] a, b;
  logic        res_ready;
  logic        in_ready_u, res_valid_u, busy_u;
  logic        in_ready_s, res_valid_s, busy_s;
  logic [19:0] res_u, res_s;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  accum_thread u_dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_ready_u), .a(a), .b(b),
    .res(res_u), .res_valid(res_valid_u), .res_ready(res_ready), .busy(busy_u)
  );

  accum_thread #(.SIGNED(1'b1)) u_dut_s (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_ready_s), .a(a), .b(b),
    .res(res_s), .res_valid(res_valid_s), .res_ready(res_ready), .busy(busy_s)
  );

  typedef struct {
    logic [4:0]        k;
    logic [3:0][31:0]  a;
    logic [3:0][31:0]  b;
    logic [19:0]       res;
    int                beats;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [31:0] pk(input int l0, input int l1, input int l2, input int l3);
    pk = {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, output logic [19:0] ru, output logic [19:0] rs,
                         output int nb, output logic lat_ok, output logic got);
    logic acc;
    start    = 1'b1;
    k_len    = v.k;
    in_valid = 1'b0;
    tick();
    start  = 1'b0;
    nb     = 0;
    got    = 1'b0;
    lat_ok = 1'b0;
    if (res_valid_u) begin
      got    = 1'b1;
      lat_ok = (v.k == 5'd0);
    end
    for (int c = 0; c < 24 && !got; c++) begin
      acc      = in_ready_u;
      in_valid = 1'b1;
      a        = (nb < 4) ? v.a[nb] : 32'hFFFF_FFFF;
      b        = (nb < 4) ? v.b[nb] : 32'hFFFF_FFFF;
      tick();
      if (acc) nb++;
      if (res_valid_u) begin
        got    = 1'b1;
        lat_ok = acc;
      end
    end
    in_valid = 1'b0;
    ru = res_u;
    rs = res_s;
  endtask

  task automatic handshake(input string name, input logic [19:0] exp_res);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({name, "_busy_after"}, busy_u, 1'b0);
    chk({name, "_res_kept"}, res_u, exp_res);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [19:0] ru, rs;
    int          nb;
    logic        lat_ok, got;
    vec_t        v;

    vecs[0] = '{k: 5'd8,  a: {32'h0, 32'h0, pk(5,6,7,8), pk(1,2,3,4)},
                          b: {32'h0, 32'h0, pk(2,2,2,2), pk(2,2,2,2)}, res: 20'd72, beats: 2};
    vecs[1] = '{k: 5'd5,  a: {32'h0, 32'h0, pk(3,9,9,9), pk(1,1,1,1)},
                          b: {32'h0, 32'h0, pk(4,9,9,9), pk(1,1,1,1)}, res: 20'd16, beats: 2};
    vecs[2] = '{k: 5'd0,  a: '0, b: '0, res: 20'd0, beats: 0};
    vecs[3] = '{k: 5'd17, a: {4{pk(1,1,1,1)}}, b: {4{pk(1,1,1,1)}}, res: 20'd16, beats: 4};
    vecs[4] = '{k: 5'd31, a: {4{pk(255,255,255,255)}}, b: {4{pk(255,255,255,255)}},
                          res: 20'd1040400, beats: 4};
    vecs[5] = '{k: 5'd3,  a: {32'h0, 32'h0, 32'h0, pk(10,20,30,99)},
                          b: {32'h0, 32'h0, 32'h0, pk(1,2,3,99)}, res: 20'd140, beats: 1};
    vecs[6] = '{k: 5'd16, a: {pk(13,14,15,16), pk(9,10,11,12), pk(5,6,7,8), pk(1,2,3,4)},
                          b: {4{pk(1,1,1,1)}}, res: 20'd136, beats: 4};

    rst = 1'b0; start = 1'b0; k_len = '0; in_valid = 1'b0;
    a = '0; b = '0; res_ready = 1'b0;
    tick();
    chk("rst_res", res_u, 20'd0);
    chk("rst_res_valid", res_valid_u, 1'b0);
    chk("rst_in_ready", in_ready_u, 1'b0);
    chk("rst_busy", busy_u, 1'b0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i], ru, rs, nb, lat_ok, got);
      chk($sformatf("v%0d_res_valid", i), got, 1'b1);
      chk($sformatf("v%0d_latency", i), lat_ok, 1'b1);
      chk($sformatf("v%0d_beats", i), nb, vecs[i].beats);
      chk($sformatf("v%0d_res", i), ru, vecs[i].res);
      handshake($sformatf("v%0d", i), vecs[i].res);
    end

    // signed: (-3*5) + (4*-2) = -23, lanes 2/3 masked
    v = '{k: 5'd2, a: {32'h0, 32'h0, 32'h0, pk(-3, 4, 7, 7)},
                   b: {32'h0, 32'h0, 32'h0, pk(5, -2, 7, 7)}, res: 20'hFFFE9, beats: 1};
    run_txn(v, ru, rs, nb, lat_ok, got);
    chk("signed_res_valid", res_valid_s, 1'b1);
    chk("signed_res", rs, 20'hFFFE9);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("signed_busy_after", busy_s, 1'b0);

    // in_valid gaps 1,0,0,1 then a stalled consumer
    start = 1'b1; k_len = 5'd8;
    tick();
    start = 1'b0;
    in_valid = 1'b1; a = pk(1,2,3,4); b = pk(2,2,2,2);
    tick();
    in_valid = 1'b0; a = pk(50,50,50,50); b = pk(50,50,50,50);
    tick();
    chk("gap_in_ready", in_ready_u, 1'b1);
    tick();
    chk("gap_no_valid", res_valid_u, 1'b0);
    in_valid = 1'b1; a = pk(5,6,7,8); b = pk(2,2,2,2);
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("stall%0d_valid", c), res_valid_u, 1'b1);
      chk($sformatf("stall%0d_res", c), res_u, 20'd72);
      tick();
    end
    res_ready = 1'b1; start = 1'b1; k_len = 5'd4;
    tick();
    res_ready = 1'b0; start = 1'b0;
    chk("gap_busy_after", busy_u, 1'b0);
    tick();
    chk("start_in_handshake_ignored", busy_u, 1'b0);

    // reset in mid-accumulation
    start = 1'b1; k_len = 5'd8;
    tick();
    start = 1'b0;
    in_valid = 1'b1; a = pk(1,1,1,1); b = pk(1,1,1,1);
    tick();
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("arst_res", res_u, 20'd0);
    chk("arst_busy", busy_u, 1'b0);
    chk("arst_in_ready", in_ready_u, 1'b0);
    chk("arst_res_valid", res_valid_u, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    tick();
    chk("post_rst_no_valid", res_valid_u, 1'b0);
    v = '{k: 5'd4, a: {4{pk(1,1,1,1)}}, b: {4{pk(1,1,1,1)}}, res: 20'd4, beats: 1};
    run_txn(v, ru, rs, nb, lat_ok, got);
    chk("post_rst_res", ru, 20'd4);
    chk("post_rst_beats", nb, 1);
    handshake("post_rst", 20'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/accum_thread.md
ACCUM_THREAD -- requirements
Module: accum_thread

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, operand width in bits.
REQ-002 SHALL have parameter ADDER_WIDTH, default 4, number of product lanes summed per beat.
REQ-003 SHALL have parameter K_MAX, default 16, maximum dot-product length in elements.
REQ-004 SHALL have parameter SIGNED, default 0; 0 treats operands as unsigned, 1 as two's complement.
REQ-005 SHALL have parameter OUTPUT_DATA_WIDTH, default 2*DATA_WIDTH+$clog2(K_MAX), result width.
REQ-006 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port start  input  1  begin a new dot product.
REQ-009 SHALL have port k_len  input  $clog2(K_MAX+1)  element count, sampled with start.
REQ-010 SHALL have port in_valid  input  1  a/b beat valid.
REQ-011 SHALL have port in_ready  output  1  block accepts a beat.
REQ-012 SHALL have port a  input  ADDER_WIDTH*DATA_WIDTH  Matrix A lanes, lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-013 SHALL have port b  input  ADDER_WIDTH*DATA_WIDTH  Matrix B lanes, same packing.
REQ-014 SHALL have port res  output  OUTPUT_DATA_WIDTH  sum of a[i]*b[i] over i in 0..k_len-1.
REQ-015 SHALL have port res_valid  output  1  res holds a completed result.
REQ-016 SHALL have port res_ready  input  1  consumer accepts res.
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-018 SHALL implement states IDLE, ACCUM, DONE.
REQ-019 IDLE: start=1 SHALL latch k_len (values above K_MAX clamped to K_MAX), clear accumulator, and go to ACCUM; k_len=0 SHALL go directly to DONE with res=0.
REQ-020 start SHALL be ignored outside IDLE.
REQ-021 in_ready SHALL be 1 only in ACCUM; a beat is accepted when in_valid & in_ready.
REQ-022 Beat count SHALL be ceil(k_len/ADDER_WIDTH); each accepted beat adds the sum of its lane products to the accumulator.
REQ-023 On the final beat, lanes with index >= remaining element count SHALL contribute zero regardless of a/b values.
REQ-024 Products SHALL be 2*DATA_WIDTH bits, zero-extended (SIGNED=0) or sign-extended (SIGNED=1) to OUTPUT_DATA_WIDTH before summation; summation wraps modulo 2^OUTPUT_DATA_WIDTH.
REQ-025 Accepting the final beat in cycle N SHALL load res and assert res_valid in cycle N+1 (state DONE).
REQ-026 In ACCUM with in_valid=0, the accumulator and beat counter SHALL hold.
REQ-027 DONE: res_valid=1 and res stable until res_valid & res_ready, then go to IDLE next cycle; res keeps its value after leaving DONE.
REQ-028 start asserted in the same cycle as the DONE->IDLE handshake SHALL be ignored; start is honoured only while in IDLE.

Reset
REQ-029 rst=0 SHALL asynchronously force state IDLE, res=0, res_valid=0, in_ready=0, busy=0, accumulator and beat counter 0.
REQ-030 Reset asserted mid-ACCUM or in DONE SHALL abandon the operation; no res_valid after release until a new start completes.

Verification
REQ-031 Unsigned, ADDER_WIDTH=4, k_len=8, a=1..8, b=all 2, in_valid held high -> 2 beats, res_valid 1 cycle after beat 2, res=72.
REQ-032 k_len=5, beat 2 lanes a={3,9,9,9}, b={4,9,9,9}, beat 1 a=b=1 -> masked lanes ignored, res=4+12=16.
REQ-033 SIGNED=1, DATA_WIDTH=8, k_len=2, a={-3,4}, b={5,-2} -> res=-23 sign-correct in OUTPUT_DATA_WIDTH.
REQ-034 k_len=8 with in_valid toggling 1,0,0,1 and res_ready=0 for 3 cycles -> res=correct sum, res_valid/res stable until res_ready=1, then busy=0 next cycle.
REQ-035 k_len=0 -> res_valid next cycle with res=0; k_len=K_MAX+1 -> exactly K_MAX/ADDER_WIDTH beats accepted.
REQ-036 rst pulsed low after 1 of 2 beats -> outputs 0 immediately; subsequent start with k_len=4, a=b=all 1 -> res=4.
